// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: sequences every write into the HI/LO register pair.
// MULT/MULTU run an iterative shift-add, DIV/DIVU an iterative restoring divide,
// both on operand magnitudes with the sign fixed up on the way out.
// MTHI/MTLO pass straight through as a one-cycle write.
module hilo_muldiv_ctrl #(
    parameter int W   = 32,
    parameter int BPC = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,       // active-low asynchronous reset
    input  logic         i_start,
    input  logic [2:0]   i_op,
    input  logic [W-1:0] i_src_a,
    input  logic [W-1:0] i_src_b,
    input  logic         i_flush,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_hi_we,
    output logic [W-1:0] o_hi_wdata,
    output logic         o_lo_we,
    output logic [W-1:0] o_lo_wdata
);

    localparam int STEPS = W / BPC;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_WRITE} state_t;

    state_t         r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_acc_hi;   // product high half / partial remainder
    logic [W-1:0]   r_acc_lo;   // multiplier bits / dividend bits turning into quotient
    logic [W-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic [W-1:0]   r_a_raw;    // original dividend, returned as HI on divide-by-zero
    logic           r_is_div;
    logic           r_neg_q;    // negate product (MULT) or quotient (DIV)
    logic           r_neg_r;    // negate remainder (DIV, follows dividend sign)
    logic           r_div0;

    logic           w_accept, w_last, w_signed, w_a_neg, w_b_neg;
    logic [W-1:0]   w_a_mag, w_b_mag;
    logic [W-1:0]   w_hi, w_lo;
    logic [W:0]     w_rem, w_sum;
    logic           w_qb;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_res_hi, w_res_lo;

    // Request handling: flush in IDLE drops a simultaneous start.
    assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;
    assign w_last   = (r_cnt == CW'(STEPS - 1));
    assign o_busy   = (r_state != S_IDLE);

    // Operand magnitudes for the signed ops (MULT=0, DIV=2).
    assign w_signed = (i_op == 3'd0) || (i_op == 3'd2);
    assign w_a_neg  = w_signed && i_src_a[W-1];
    assign w_b_neg  = w_signed && i_src_b[W-1];
    assign w_a_mag  = w_a_neg ? -i_src_a : i_src_a;
    assign w_b_mag  = w_b_neg ? -i_src_b : i_src_b;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: CALC runs STEPS cycles unless flushed; WRITE always completes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !i_op[2]) w_state_nxt = S_CALC;
            S_CALC:  if (i_flush)              w_state_nxt = S_IDLE;
                     else if (w_last)          w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // BPC iteration steps per cycle: shift-add multiply or restoring divide.
    always_comb begin
        w_hi  = r_acc_hi;
        w_lo  = r_acc_lo;
        w_rem = '0;
        w_sum = '0;
        w_qb  = 1'b0;
        for (int k = 0; k < BPC; k++) begin
            if (r_is_div) begin
                w_rem = {w_hi, w_lo[W-1]};
                w_qb  = (w_rem >= {1'b0, r_opnd});
                if (w_qb) w_rem = w_rem - {1'b0, r_opnd};
                w_hi  = w_rem[W-1:0];
                w_lo  = {w_lo[W-2:0], w_qb};
            end else begin
                w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : '0);
                w_lo  = {w_sum[0], w_lo[W-1:1]};
                w_hi  = w_sum[W:1];
            end
        end
    end

    // Sign fix-up and divide-by-zero override applied to the final step's result.
    always_comb begin
        w_prod   = {w_hi, w_lo};
        w_res_hi = '0;
        w_res_lo = '0;
        if (r_is_div) begin
            if (r_div0) begin
                w_res_lo = '1;
                w_res_hi = r_a_raw;
            end else begin
                w_res_lo = r_neg_q ? -w_lo : w_lo;
                w_res_hi = r_neg_r ? -w_hi : w_hi;
            end
        end else begin
            if (r_neg_q) w_prod = -w_prod;
            w_res_hi = w_prod[2*W-1:W];
            w_res_lo = w_prod[W-1:0];
        end
    end

    // Datapath and registered write port; we/done default low every cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opnd     <= '0;
            r_a_raw    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div0     <= 1'b0;
            o_done     <= 1'b0;
            o_hi_we    <= 1'b0;
            o_lo_we    <= 1'b0;
            o_hi_wdata <= '0;
            o_lo_wdata <= '0;
        end else begin
            o_done  <= 1'b0;
            o_hi_we <= 1'b0;
            o_lo_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (i_op)
                            3'd4: begin
                                o_hi_we    <= 1'b1;
                                o_hi_wdata <= i_src_a;
                            end
                            3'd5: begin
                                o_lo_we    <= 1'b1;
                                o_lo_wdata <= i_src_a;
                            end
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                r_cnt    <= '0;
                                r_acc_hi <= '0;
                                r_acc_lo <= i_op[1] ? w_a_mag : w_b_mag;
                                r_opnd   <= i_op[1] ? w_b_mag : w_a_mag;
                                r_a_raw  <= i_src_a;
                                r_is_div <= i_op[1];
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_div0   <= i_op[1] && (i_src_b == '0);
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (!i_flush) begin
                        r_acc_hi <= w_hi;
                        r_acc_lo <= w_lo;
                        r_cnt    <= r_cnt + CW'(1);
                        if (w_last) begin
                            o_done     <= 1'b1;
                            o_hi_we    <= 1'b1;
                            o_lo_we    <= 1'b1;
                            o_hi_wdata <= w_res_hi;
                            o_lo_wdata <= w_res_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases plus random MULT/DIV
// operations compared against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;

    logic        clk, rst, start, flush;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, done, hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;

    int errors = 0;
    int checks = 0;

    hilo_muldiv_ctrl #(.W(32), .BPC(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
        .i_src_a(src_a), .i_src_b(src_b), .i_flush(flush),
        .o_busy(busy), .o_done(done), .o_hi_we(hi_we), .o_hi_wdata(hi_wdata),
        .o_lo_we(lo_we), .o_lo_wdata(lo_wdata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference: plain arithmetic on the architectural definition of each op.
    function automatic void model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint      sp;
        logic [63:0] up;
        hi = '0; lo = '0;
        case (mop)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {hi, lo} = 64'(sp);
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                {hi, lo} = up;
            end
            3'd2: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
                else begin
                    lo = $signed(a) / $signed(b);
                    hi = $signed(a) % $signed(b);
                end
            end
            3'd3: begin
                if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            default: ;
        endcase
    endfunction

    // One MULT/DIV run; optional flush in CALC cycle flush_at, optional stray start at poke_at.
    task automatic run_md(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int poke_at, input string name);
        logic [31:0] eh, el, got_h, got_l, hold_h, hold_l;
        int done_cyc, n_done, n_hwe, n_lwe, n_busy;
        model(mop, a, b, eh, el);
        done_cyc = 0; n_done = 0; n_hwe = 0; n_lwe = 0; n_busy = 0;
        got_h = 'x; got_l = 'x; hold_h = 'x; hold_l = 'x;
        @(negedge clk);
        start = 1; op = mop; src_a = a; src_b = b;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) begin n_done++; if (done_cyc == 0) done_cyc = c; end
            if (hi_we) begin n_hwe++; got_h = hi_wdata; end
            if (lo_we) begin n_lwe++; got_l = lo_wdata; end
            if (c == 36) begin hold_h = hi_wdata; hold_l = lo_wdata; end
            start = (c == poke_at);
            if (c == poke_at) begin op = 3'd4; src_a = 32'hDEAD_BEEF; end
            flush = (c == flush_at);
        end
        start = 0; flush = 0;
        if (flush_at > 0) begin
            checks++; if (n_busy !== flush_at) begin errors++; $display("FAIL %s flush busy cycles: got %0d want %0d", name, n_busy, flush_at); end
            checks++; if (n_done !== 0) begin errors++; $display("FAIL %s flush done: got %0d pulses want 0", name, n_done); end
            checks++; if (n_hwe + n_lwe !== 0) begin errors++; $display("FAIL %s flush writes: got %0d want 0", name, n_hwe + n_lwe); end
        end else begin
            checks++; if (done_cyc !== 33) begin errors++; $display("FAIL %s latency: done at cycle %0d want 33", name, done_cyc); end
            checks++; if (n_done !== 1) begin errors++; $display("FAIL %s done count: got %0d want 1", name, n_done); end
            checks++; if (n_busy !== 33) begin errors++; $display("FAIL %s busy cycles: got %0d want 33", name, n_busy); end
            checks++; if (n_hwe !== 1 || n_lwe !== 1) begin errors++; $display("FAIL %s we count: hi %0d lo %0d want 1/1", name, n_hwe, n_lwe); end
            checks++; if (got_h !== eh) begin errors++; $display("FAIL %s HI: got %h want %h (a=%h b=%h)", name, got_h, eh, a, b); end
            checks++; if (got_l !== el) begin errors++; $display("FAIL %s LO: got %h want %h (a=%h b=%h)", name, got_l, el, a, b); end
            checks++; if (hold_h !== eh || hold_l !== el) begin errors++; $display("FAIL %s wdata hold: got %h/%h want %h/%h", name, hold_h, hold_l, eh, el); end
        end
    endtask

    task automatic test_reset();
        rst = 0; start = 0; flush = 0; op = 0; src_a = 0; src_b = 0;
        @(negedge clk);
        checks++;
        if ({busy, done, hi_we, lo_we, hi_wdata, lo_wdata} !== '0) begin
            errors++; $display("FAIL reset: busy=%b done=%b we=%b%b wdata=%h/%h want all 0", busy, done, hi_we, lo_we, hi_wdata, lo_wdata);
        end
        rst = 1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset release busy: got %b want 0", busy); end
    endtask

    task automatic test_muldiv_directed();
        run_md(3'd0, 32'hFFFF_FFFF, 32'd2, 0, 0, "mult_m1x2");
        run_md(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 15, "multu_poke");
        run_md(3'd2, -32'sd7, 32'd2, 0, 0, "div_m7_2");
        run_md(3'd3, 32'd100, 32'd7, 0, 0, "divu_100_7");
        run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
        run_md(3'd3, 32'd5, 32'd0, 0, 0, "divu_by0");
        run_md(3'd2, -32'sd9, 32'd0, 0, 0, "div_by0");
    endtask

    task automatic test_mthi_mtlo();
        int n_busy;
        n_busy = 0;
        @(negedge clk);
        start = 1; op = 3'd4; src_a = 32'h1234;
        @(negedge clk);
        if (busy) n_busy++;
        checks++; if (hi_we !== 1'b1 || lo_we !== 1'b0 || hi_wdata !== 32'h1234) begin
            errors++; $display("FAIL mthi: we=%b%b wdata=%h want 10/00001234", hi_we, lo_we, hi_wdata); end
        op = 3'd5; src_a = 32'h5678;
        @(negedge clk);
        if (busy) n_busy++;
        checks++; if (lo_we !== 1'b1 || hi_we !== 1'b0 || lo_wdata !== 32'h5678) begin
            errors++; $display("FAIL mtlo: we=%b%b wdata=%h want 01/00005678", hi_we, lo_we, lo_wdata); end
        start = 0;
        @(negedge clk);
        if (busy) n_busy++;
        checks++; if (hi_we !== 1'b0 || lo_we !== 1'b0 || hi_wdata !== 32'h1234 || lo_wdata !== 32'h5678) begin
            errors++; $display("FAIL mt idle: we=%b%b wdata=%h/%h want 00 and held", hi_we, lo_we, hi_wdata, lo_wdata); end
        checks++; if (n_busy !== 0) begin errors++; $display("FAIL mt busy: got %0d cycles want 0", n_busy); end
    endtask

    task automatic test_nop_and_idle_flush();
        int n_act;
        n_act = 0;
        @(negedge clk);
        start = 1; op = 3'd6; src_a = 32'hAAAA_5555;
        @(negedge clk);
        n_act += int'(busy) + int'(hi_we) + int'(lo_we) + int'(done);
        op = 3'd7;
        @(negedge clk);
        n_act += int'(busy) + int'(hi_we) + int'(lo_we) + int'(done);
        op = 3'd0; src_b = 32'd3; flush = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            start = 0; flush = 0;
            n_act += int'(busy) + int'(hi_we) + int'(lo_we) + int'(done);
        end
        checks++; if (n_act !== 0) begin errors++; $display("FAIL nop/idle_flush activity: got %0d want 0", n_act); end
    endtask

    task automatic test_flush();
        run_md(3'd3, 32'd1000, 32'd3, 10, 0, "divu_flush");
        run_md(3'd0, 32'd123, -32'sd45, 0, 0, "mult_after_flush");
    endtask

    task automatic test_rst_mid();
        int n_act;
        n_act = 0;
        @(negedge clk);
        start = 1; op = 3'd0; src_a = 32'd77; src_b = 32'd11;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 0;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid running: busy=%b want 1", busy); end
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if ({busy, done, hi_we, lo_we, hi_wdata, lo_wdata} !== '0) begin
            errors++; $display("FAIL rst_mid outputs: busy=%b done=%b we=%b%b wdata=%h/%h want all 0", busy, done, hi_we, lo_we, hi_wdata, lo_wdata);
        end
        @(negedge clk);
        rst = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_act += int'(busy) + int'(hi_we) + int'(lo_we) + int'(done);
        end
        checks++; if (n_act !== 0) begin errors++; $display("FAIL rst_mid aftermath: activity %0d want 0", n_act); end
        start = 1; op = 3'd5; src_a = 32'hCAFE_0001;
        @(negedge clk);
        start = 0;
        checks++; if (lo_we !== 1'b1 || hi_we !== 1'b0 || lo_wdata !== 32'hCAFE_0001) begin
            errors++; $display("FAIL rst_mid mtlo: we=%b%b wdata=%h want 01/cafe0001", hi_we, lo_we, lo_wdata); end
    endtask

    task automatic test_random();
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_md(rop, ra, rb, 0, 0, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_muldiv_directed();
        test_mthi_mtlo();
        test_nop_and_idle_flush();
        test_flush();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
